// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
// Imported by the interface, the timer and the top level.
package lock_pkg;

    localparam int DIGIT_W = 4;
    localparam int TMR_W   = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ENTRY    = 3'd1;
    localparam state_t ST_CHECK    = 3'd2;
    localparam state_t ST_UNLOCKED = 3'd3;
    localparam state_t ST_PROGRAM  = 3'd4;
    localparam state_t ST_FAIL     = 3'd5;
    localparam state_t ST_LOCKOUT  = 3'd6;

    function automatic logic [1:0] sat_inc(
        input logic [1:0] v,
        input logic [1:0] lim
    );
        return (v >= lim) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad inputs and lock status outputs between a keypad source
// (master) and the lock controller (slave).
interface lock_controller_if;
    import lock_pkg::*;

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               key_enter;
    logic               key_clear;
    logic               prog_req;
    logic               unlock;
    logic               alarm;
    logic               locked_out;
    logic               busy;
    logic [1:0]         fail_count;

    modport master (
        output key_valid, key_digit, key_enter, key_clear, prog_req,
        input  unlock, alarm, locked_out, busy, fail_count
    );

    modport slave (
        input  key_valid, key_digit, key_enter, key_clear, prog_req,
        output unlock, alarm, locked_out, busy, fail_count
    );

endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock hold and the lockout.
// Stops at zero; done is high while the count is zero.
module lock_timer
    import lock_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    // load wins, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad door lock: code entry, check, timed unlock, password
// programming and timed lockout after repeated failures.
module lock_controller
    import lock_pkg::*;
#(
    parameter int                    DIGITS         = 4,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    UNLOCK_CYCLES  = 16,
    parameter int                    LOCKOUT_CYCLES = 64,
    parameter logic [4*DIGITS-1:0]   DEFAULT_CODE   = 16'hA5A5
) (
    input logic              clk,
    input logic              reset,
    lock_controller_if.slave bus
);

    localparam int CODE_W = DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    state_t            state, state_nx;
    logic [CODE_W-1:0] code_buf, buf_nx;
    logic [CODE_W-1:0] pw, pw_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              ovf, ovf_nx;
    logic [1:0]        fail_cnt, fail_nx;

    logic              t_load;
    logic              t_en;
    logic [TMR_W-1:0]  t_val;
    logic              t_done;

    logic              full;
    logic              match;
    logic [CODE_W-1:0] shifted;

    assign full    = (cnt == CNT_W'(DIGITS));
    assign match   = full && !ovf && (code_buf == pw);
    assign shifted = (code_buf << DIGIT_W) | CODE_W'(bus.key_digit);

    lock_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .en       (t_en),
        .load_val (t_val),
        .done     (t_done)
    );

    // next-state and datapath updates, clear > enter > digit
    always_comb begin
        state_nx = state;
        buf_nx   = code_buf;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        pw_nx    = pw;
        fail_nx  = fail_cnt;
        t_load   = 1'b0;
        t_en     = 1'b0;
        t_val    = '0;
        case (state)
            ST_IDLE: begin
                if (bus.key_clear) begin
                    buf_nx = '0;
                    cnt_nx = '0;
                    ovf_nx = 1'b0;
                end else if (bus.key_enter) begin
                    state_nx = ST_IDLE;
                end else if (bus.key_valid) begin
                    buf_nx   = CODE_W'(bus.key_digit);
                    cnt_nx   = CNT_W'(1);
                    ovf_nx   = 1'b0;
                    state_nx = ST_ENTRY;
                end
            end
            ST_ENTRY, ST_PROGRAM: begin
                if (bus.key_clear) begin
                    buf_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = ST_IDLE;
                end else if (bus.key_enter) begin
                    if (state == ST_ENTRY) begin
                        state_nx = ST_CHECK;
                    end else begin
                        if (full && !ovf) begin
                            pw_nx = code_buf;
                        end
                        buf_nx   = '0;
                        cnt_nx   = '0;
                        ovf_nx   = 1'b0;
                        state_nx = ST_IDLE;
                    end
                end else if (bus.key_valid) begin
                    if (full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        buf_nx = shifted;
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                buf_nx = '0;
                cnt_nx = '0;
                ovf_nx = 1'b0;
                t_load = 1'b1;
                if (match) begin
                    fail_nx  = 2'd0;
                    t_val    = TMR_W'(UNLOCK_CYCLES - 1);
                    state_nx = ST_UNLOCKED;
                end else begin
                    fail_nx = sat_inc(fail_cnt, 2'(MAX_TRIES));
                    if (fail_nx >= 2'(MAX_TRIES)) begin
                        t_val    = TMR_W'(LOCKOUT_CYCLES - 1);
                        state_nx = ST_LOCKOUT;
                    end else begin
                        t_load   = 1'b0;
                        state_nx = ST_FAIL;
                    end
                end
            end
            ST_UNLOCKED: begin
                t_en = 1'b1;
                if (t_done) begin
                    state_nx = ST_IDLE;
                end else if (bus.prog_req) begin
                    buf_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = ST_PROGRAM;
                end
            end
            ST_FAIL: begin
                state_nx = ST_IDLE;
            end
            ST_LOCKOUT: begin
                t_en = 1'b1;
                if (t_done) begin
                    fail_nx  = 2'd0;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // state, entry buffer, password and failure count
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            code_buf <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            pw       <= DEFAULT_CODE;
            fail_cnt <= 2'd0;
        end else begin
            state    <= state_nx;
            code_buf <= buf_nx;
            cnt      <= cnt_nx;
            ovf      <= ovf_nx;
            pw       <= pw_nx;
            fail_cnt <= fail_nx;
        end
    end

    // registered Moore outputs decoded from the current state
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.unlock     <= 1'b0;
            bus.alarm      <= 1'b0;
            bus.locked_out <= 1'b0;
            bus.busy       <= 1'b0;
            bus.fail_count <= 2'd0;
        end else begin
            bus.unlock     <= (state == ST_UNLOCKED);
            bus.alarm      <= (state == ST_FAIL) ||
                              (state == ST_LOCKOUT);
            bus.locked_out <= (state == ST_LOCKOUT);
            bus.busy       <= (state != ST_IDLE);
            bus.fail_count <= fail_cnt;
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: timeline model of expected outputs
// checked every cycle, plus literal spot checks.
module tb_lock_controller;
    import lock_pkg::*;

    localparam int N = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lock_controller_if bus();

    lock_controller #(
        .DIGITS         (4),
        .MAX_TRIES      (3),
        .UNLOCK_CYCLES  (16),
        .LOCKOUT_CYCLES (64),
        .DEFAULT_CODE   (16'hA5A5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit e_unl [N];
    bit e_alm [N];
    bit e_lo  [N];
    bit e_busy[N];
    int e_fc  [N];

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_pw = 16'hA5A5;
    int m_fc = 0;
    int idle_at = 0;
    int unl_end = 0;

    int unl_cnt = 0;
    int alm_cnt = 0;
    int lo_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void mark(input int a, input int b,
                                 input bit u, input bit al,
                                 input bit lo);
        for (int i = a; i <= b && i < N; i++) begin
            e_unl[i] = u;
            e_alm[i] = al;
            e_lo[i]  = lo;
        end
    endfunction

    function automatic void busy_from(input int a, input bit v);
        for (int i = a; i < N; i++) e_busy[i] = v;
    endfunction

    function automatic void fc_from(input int a, input int v);
        for (int i = a; i < N; i++) e_fc[i] = v;
    endfunction

    // every-cycle comparison against the timeline model
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            chk("unlock", 32'(bus.unlock), 32'(e_unl[cyc]));
            chk("alarm", 32'(bus.alarm), 32'(e_alm[cyc]));
            chk("locked_out", 32'(bus.locked_out), 32'(e_lo[cyc]));
            chk("busy", 32'(bus.busy), 32'(e_busy[cyc]));
            chk("fail_count", 32'(bus.fail_count), e_fc[cyc]);
            chk("unlock_alarm_excl",
                32'(bus.unlock & bus.alarm), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (bus.unlock === 1'b1) unl_cnt++;
        if (bus.alarm === 1'b1) alm_cnt++;
        if (bus.locked_out === 1'b1) lo_cnt++;
    end

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        @(negedge clk);
        bus.key_enter = 1'b0;
    endtask

    task automatic keys(input logic [31:0] code, input int n);
        for (int i = 0; i < n; i++) press(code[4*(n-1-i) +: 4]);
    endtask

    task automatic attempt(input logic [31:0] code, input int n,
                           output int e);
        busy_from(cyc + 2, 1'b1);
        keys(code, n);
        e = cyc + 1;
        enter();
        if (n == 4 && code[15:0] == m_pw) begin
            mark(e + 2, e + 17, 1'b1, 1'b0, 1'b0);
            busy_from(e + 18, 1'b0);
            m_fc = 0;
            fc_from(e + 2, 0);
            idle_at = e + 17;
            unl_end = e + 17;
        end else begin
            m_fc = (m_fc < 3) ? m_fc + 1 : 3;
            fc_from(e + 2, m_fc);
            if (m_fc == 3) begin
                mark(e + 2, e + 65, 1'b0, 1'b1, 1'b1);
                busy_from(e + 66, 1'b0);
                fc_from(e + 66, 0);
                m_fc = 0;
                idle_at = e + 65;
            end else begin
                mark(e + 2, e + 2, 1'b0, 1'b1, 1'b0);
                busy_from(e + 3, 1'b0);
                idle_at = e + 2;
            end
        end
    endtask

    task automatic prog(input logic [31:0] code, input int n);
        int p;
        int e2;
        p = cyc + 1;
        bus.prog_req = 1'b1;
        @(negedge clk);
        bus.prog_req = 1'b0;
        mark(p + 1, unl_end, 1'b0, 1'b0, 1'b0);
        busy_from(p + 1, 1'b1);
        keys(code, n);
        e2 = cyc + 1;
        enter();
        if (n == 4) m_pw = code[15:0];
        busy_from(e2 + 1, 1'b0);
        idle_at = e2;
    endtask

    task automatic wait_idle();
        while (cyc < idle_at) @(negedge clk);
    endtask

    task automatic skip(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int r;
        int c;
        reset = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        bus.prog_req  = 1'b0;
        skip(2);
        reset = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_fc", 32'(bus.fail_count), 32'd0);

        // correct default code: unlock at +2 for 16 cycles
        unl_cnt = 0;
        alm_cnt = 0;
        attempt(32'hA5A5, 4, e);
        skip(1);
        chk("t1_unlock_e1", 32'(bus.unlock), 32'd0);
        skip(1);
        chk("t1_unlock_e2", 32'(bus.unlock), 32'd1);
        chk("t1_fc", 32'(bus.fail_count), 32'd0);
        skip(20);
        chk("t1_unlock_len", unl_cnt, 32'd16);
        chk("t1_alarm_none", alm_cnt, 32'd0);

        // enter alone in idle is ignored
        enter();
        skip(2);
        chk("idle_enter_busy", 32'(bus.busy), 32'd0);

        // clear together with enter mid-entry
        busy_from(cyc + 2, 1'b1);
        keys(32'hA5, 2);
        c = cyc + 1;
        bus.key_clear = 1'b1;
        bus.key_enter = 1'b1;
        @(negedge clk);
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
        busy_from(c + 1, 1'b0);
        skip(3);
        chk("clr_fc", 32'(bus.fail_count), 32'd0);
        chk("clr_alarm", 32'(bus.alarm), 32'd0);

        // five digits (first four right), then three digits
        attempt(32'hA5A51, 5, e);
        skip(2);
        chk("five_fc", 32'(bus.fail_count), 32'd1);
        chk("five_alarm", 32'(bus.alarm), 32'd1);
        wait_idle();
        attempt(32'hA5A, 3, e);
        skip(2);
        chk("three_fc", 32'(bus.fail_count), 32'd2);
        wait_idle();
        attempt(32'hA5A5, 4, e);
        skip(2);
        chk("match_fc_clr", 32'(bus.fail_count), 32'd0);
        wait_idle();

        // three wrong codes lead to lockout
        attempt(32'h1234, 4, e);
        skip(2);
        chk("lk1_fc", 32'(bus.fail_count), 32'd1);
        chk("lk1_alarm", 32'(bus.alarm), 32'd1);
        wait_idle();
        attempt(32'h1234, 4, e);
        skip(2);
        chk("lk2_fc", 32'(bus.fail_count), 32'd2);
        wait_idle();
        lo_cnt = 0;
        unl_cnt = 0;
        attempt(32'h1234, 4, e);
        skip(2);
        chk("lk3_lo", 32'(bus.locked_out), 32'd1);
        chk("lk3_alarm", 32'(bus.alarm), 32'd1);
        keys(32'hA5A5, 4);
        enter();
        wait_idle();
        skip(3);
        chk("lk_len", lo_cnt, 32'd64);
        chk("lk_no_unlock", unl_cnt, 32'd0);
        chk("lk_fc_clr", 32'(bus.fail_count), 32'd0);

        // program a new password while unlocked
        attempt(32'hA5A5, 4, e);
        skip(2);
        prog(32'h1234, 4);
        wait_idle();
        attempt(32'hA5A5, 4, e);
        skip(2);
        chk("old_pw_alarm", 32'(bus.alarm), 32'd1);
        wait_idle();
        attempt(32'h1234, 4, e);
        skip(2);
        chk("new_pw_unlock", 32'(bus.unlock), 32'd1);
        prog(32'h777, 3);
        wait_idle();
        attempt(32'h1234, 4, e);
        skip(2);
        chk("short_prog_kept", 32'(bus.unlock), 32'd1);
        wait_idle();

        // reset in lockout restores the default password
        attempt(32'h0000, 4, e);
        wait_idle();
        attempt(32'h0000, 4, e);
        wait_idle();
        attempt(32'h0000, 4, e);
        skip(10);
        r = cyc + 1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mark(r, N - 1, 1'b0, 1'b0, 1'b0);
        busy_from(r, 1'b0);
        fc_from(r, 0);
        m_fc = 0;
        m_pw = 16'hA5A5;
        idle_at = r;
        chk("rst_unlock", 32'(bus.unlock), 32'd0);
        chk("rst_alarm", 32'(bus.alarm), 32'd0);
        chk("rst_lo", 32'(bus.locked_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fc", 32'(bus.fail_count), 32'd0);
        attempt(32'hA5A5, 4, e);
        skip(2);
        chk("rst_pw_unlock", 32'(bus.unlock), 32'd1);
        wait_idle();
        skip(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, the number of 4-bit keypad digits per code.
REQ-002 The block SHALL have parameter MAX_TRIES, default 3, the consecutive failed attempts that trigger lockout.
REQ-003 The block SHALL have parameter UNLOCK_CYCLES, default 16, the unlock hold time in clocks.
REQ-004 The block SHALL have parameter LOCKOUT_CYCLES, default 64, the lockout time in clocks.
REQ-005 The block SHALL have parameter DEFAULT_CODE, default 16'hA5A5 (width 4*DIGITS), the password loaded at reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the clock.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port key_valid, input, 1 bit: a digit strobe, one cycle per key.
REQ-009 The block SHALL have port key_digit, input, 4 bits: the digit value, qualified by key_valid.
REQ-010 The block SHALL have port key_enter, input, 1 bit: submit the entered code.
REQ-011 The block SHALL have port key_clear, input, 1 bit: abandon the current entry.
REQ-012 The block SHALL have port prog_req, input, 1 bit: request a password change, honoured only while unlocked.
REQ-013 The block SHALL have port unlock, output, 1 bit: the door release.
REQ-014 The block SHALL have port alarm, output, 1 bit: the alarm indication.
REQ-015 The block SHALL have port locked_out, output, 1 bit: lockout in progress.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted in every state except IDLE.
REQ-017 The block SHALL have port fail_count, output, 2 bits: the consecutive failed attempts so far.

Function
REQ-018 All outputs SHALL be registered, Moore-decoded from state.
REQ-019 The FSM SHALL have exactly the states IDLE, ENTRY, CHECK, UNLOCKED, PROGRAM, FAIL and LOCKOUT.
REQ-020 In IDLE, key_valid SHALL load the digit into the entry buffer, set digit count to 1 and move to ENTRY.
REQ-021 In ENTRY, key_valid SHALL shift the digit in, LSB nibble newest, while count < DIGITS.
REQ-022 In ENTRY, key_valid at count = DIGITS SHALL discard the digit and set the overflow flag.
REQ-023 Input priority SHALL be key_clear > key_enter > key_valid, and any lower-priority input in the same cycle SHALL be dropped.
REQ-024 key_clear in ENTRY or PROGRAM SHALL clear the buffer and count, return to IDLE and consume no attempt.
REQ-025 key_enter in IDLE SHALL be ignored.
REQ-026 key_enter in ENTRY SHALL move the FSM to CHECK.
REQ-027 In CHECK, a match SHALL be declared only if count = DIGITS, overflow is clear and buffer = password.
REQ-028 On a match, the FSM SHALL go to UNLOCKED and fail_count SHALL clear.
REQ-029 On a mismatch, fail_count SHALL increment, then the FSM SHALL go to LOCKOUT if fail_count reaches MAX_TRIES, else to FAIL.
REQ-030 unlock SHALL first be high exactly 2 edges after the edge sampling key_enter, and SHALL stay high for UNLOCK_CYCLES clocks.
REQ-031 When the unlock hold expires, the FSM SHALL return to IDLE.
REQ-032 In UNLOCKED, key inputs SHALL be ignored.
REQ-033 prog_req in UNLOCKED SHALL move the FSM to PROGRAM, deassert unlock and clear the buffer.
REQ-034 In PROGRAM, digits SHALL be collected as in ENTRY.
REQ-035 key_enter in PROGRAM with count = DIGITS and no overflow SHALL write the buffer to the password register, then go to IDLE.
REQ-036 key_enter in PROGRAM with any other count or with overflow SHALL leave the password unchanged, then go to IDLE.
REQ-037 FAIL SHALL last exactly 1 cycle with alarm = 1, then go to IDLE.
REQ-038 In LOCKOUT, alarm and locked_out SHALL both be 1 for LOCKOUT_CYCLES clocks and all key and prog inputs SHALL be ignored.
REQ-039 On LOCKOUT exit, fail_count SHALL clear and the FSM SHALL go to IDLE.
REQ-040 unlock and alarm SHALL never be high in the same cycle.
REQ-041 fail_count SHALL saturate at MAX_TRIES.
REQ-042 The hold/lockout timer SHALL load on state entry, count down to 0 and never wrap.

Reset
REQ-043 When reset is high at an edge, state SHALL go to IDLE, buffer, count, overflow, timer and fail_count SHALL clear, and password SHALL load DEFAULT_CODE.
REQ-044 After reset, unlock, alarm, locked_out and busy SHALL all be 0.
REQ-045 Reset SHALL take priority over all inputs.
REQ-046 Reset SHALL abort any state mid-operation, including LOCKOUT and PROGRAM; a PROGRAM in progress SHALL be discarded.

Structure
REQ-047 Package lock_pkg SHALL hold the state enum, DIGIT_W = 4 and the timer width constant.
REQ-048 Sub-module lock_timer SHALL be a loadable down-counter with a done flag, shared by UNLOCKED and LOCKOUT.
REQ-049 The password register and the comparator SHALL be implemented inside lock_controller.

Verification
REQ-050 The bench SHALL cover: digits A,5,A,5 then enter -> unlock = 1 at edge +2 for 16 cycles, alarm = 0 throughout, fail_count = 0.
REQ-051 The bench SHALL cover: digits 1,2,3,4 then enter, three times -> FAIL pulses with fail_count 1 and 2, then locked_out = alarm = 1 for 64 cycles; a correct code entered during lockout is ignored.
REQ-052 The bench SHALL cover: 5 digits, or 3 digits, then enter -> mismatch and fail_count increments, even when the first four digits are correct.
REQ-053 The bench SHALL cover: unlock, then prog_req, then 1,2,3,4 and enter -> A5A5 now fails and 1234 unlocks.
REQ-054 The bench SHALL cover: key_clear together with key_enter mid-entry -> IDLE, no attempt consumed.
REQ-055 The bench SHALL cover: reset in LOCKOUT -> all outputs 0 next cycle and password reverts to A5A5.
